// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: counter encodings,
// reset value and the RV32 conditional-branch opcode.
package branch_predictor_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    localparam bp_ctr_e BP_RESET_CTR = BP_WNT;

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit saturating counters with one combinational
// read port and one synchronous update port; single-cycle reset fill.
module bp_pht
    import branch_predictor_pkg::*;
#(
    parameter  int PHT_ENTRIES = 64,
    localparam int IDX_W       = $clog2(PHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [PHT_ENTRIES];

    function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken && cur != BP_ST) begin
            nxt = cur + 2'd1;
        end else if (!taken && cur != BP_SNT) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

    // No write-to-read bypass: a same-cycle lookup sees the old counter.
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                ctr[i] <= BP_RESET_CTR;
            end
        end else if (wr_en) begin
            ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor in ID: hashed lookup, speculative global history,
// ID->EX shadow of each prediction, training and history repair at resolve.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter  int PHT_ENTRIES = 64,
    parameter  int GHR_BITS    = 6,
    localparam int IDX_W       = $clog2(PHT_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic        id_stall,
    input  logic        ex_hold,
    input  logic        ex_flush,
    input  logic        ex_resolve_valid,
    input  logic        ex_actual_taken,
    output logic        id_br_taken,
    output logic        ex_pred_valid,
    output logic        ex_mispredict
);

    logic [GHR_BITS-1:0] ghr;
    logic [IDX_W-1:0]    idx;
    logic [1:0]          rd_ctr;
    logic                is_branch;
    logic                id_advance;
    logic                res_acc;

    logic                vld_p1;
    logic [IDX_W-1:0]    idx_p1;
    logic                pred_p1;
    logic [GHR_BITS-1:0] snap_p1;

    logic unused_bits;
    assign unused_bits = ^{id_inst[31:7], id_pc[31:IDX_W+2], id_pc[1:0], snap_p1[GHR_BITS-1]};

    // ID stage: index hash and lookup
    assign is_branch   = (id_inst[6:0] == OPC_BRANCH);
    assign idx         = id_pc[IDX_W+1:2] ^ IDX_W'(ghr);
    assign id_br_taken = is_branch & rd_ctr[1];
    assign id_advance  = !(id_stall || ex_hold || ex_flush);

    assign res_acc       = ex_resolve_valid & vld_p1;
    assign ex_pred_valid = vld_p1;
    assign ex_mispredict = res_acc & (ex_actual_taken != pred_p1);

    bp_pht #(
        .PHT_ENTRIES(PHT_ENTRIES)
    ) u_pht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (idx),
        .rd_ctr  (rd_ctr),
        .wr_en   (res_acc),
        .wr_idx  (idx_p1),
        .wr_taken(ex_actual_taken)
    );

    // Repair uses the pre-shift snapshot, so it overrides any speculative shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (ex_mispredict) begin
            ghr <= {snap_p1[GHR_BITS-2:0], ex_actual_taken};
        end else if (id_advance && is_branch) begin
            ghr <= {ghr[GHR_BITS-2:0], id_br_taken};
        end
    end

    // ID->EX boundary: shadow valid; an accepted resolve under hold clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (ex_hold) begin
            if (res_acc) begin
                vld_p1 <= 1'b0;
            end
        end else if (ex_flush || id_stall) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= is_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (id_advance) begin
            idx_p1  <= idx;
            pred_p1 <= id_br_taken;
            snap_p1 <= ghr;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed predictions, counter
// values and history after reset, training, stall, hold, flush and reset.
module tb_branch_predictor;

    localparam logic [31:0] BEQ = 32'h0000_0063;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_stall;
    logic        ex_hold;
    logic        ex_flush;
    logic        ex_resolve_valid;
    logic        ex_actual_taken;
    logic        id_br_taken;
    logic        ex_pred_valid;
    logic        ex_mispredict;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    branch_predictor #(
        .PHT_ENTRIES(64),
        .GHR_BITS   (6)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_inst         (id_inst),
        .id_pc           (id_pc),
        .id_stall        (id_stall),
        .ex_hold         (ex_hold),
        .ex_flush        (ex_flush),
        .ex_resolve_valid(ex_resolve_valid),
        .ex_actual_taken (ex_actual_taken),
        .id_br_taken     (id_br_taken),
        .ex_pred_valid   (ex_pred_valid),
        .ex_mispredict   (ex_mispredict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctr_at(input int i);
        return 32'(dut.u_pht.ctr[i]);
    endfunction

    // Branch in ID for one cycle, then resolved in EX the next cycle.
    task automatic branch_cycle(input string tag, input logic [31:0] pc,
                                input logic actual, input logic exp_pred);
        id_inst = BEQ;
        id_pc   = pc;
        #1;
        check({tag, "_pred"}, 32'(id_br_taken), 32'(exp_pred));
        step();
        id_inst          = NOP;
        ex_resolve_valid = 1'b1;
        ex_actual_taken  = actual;
        ex_flush         = (actual != exp_pred);
        #1;
        check({tag, "_mis"}, 32'(ex_mispredict), 32'(actual != exp_pred));
        step();
        ex_resolve_valid = 1'b0;
        ex_flush         = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        id_inst          = NOP;
        id_pc            = 32'h0;
        id_stall         = 1'b0;
        ex_hold          = 1'b0;
        ex_flush         = 1'b0;
        ex_resolve_valid = 1'b0;
        ex_actual_taken  = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_valid", 32'(ex_pred_valid), 0);
        check("rst_mis", 32'(ex_mispredict), 0);
        check("rst_ghr", 32'(dut.ghr), 0);
        check("rst_ctr0", ctr_at(0), 1);
        check("rst_ctr63", ctr_at(63), 1);

        // First branch: WNT predicts not taken, resolves taken
        branch_cycle("t1", 32'h100, 1'b1, 1'b0);
        check("t1_ctr0", ctr_at(0), 2);
        check("t1_ghr", 32'(dut.ghr), 1);
        check("t1_valid", 32'(ex_pred_valid), 0);

        // Fill history with ones: ghr 1,3,7,15,31 index untrained counters
        branch_cycle("p1", 32'h100, 1'b1, 1'b0);
        branch_cycle("p2", 32'h100, 1'b1, 1'b0);
        branch_cycle("p3", 32'h100, 1'b1, 1'b0);
        branch_cycle("p4", 32'h100, 1'b1, 1'b0);
        branch_cycle("p5", 32'h100, 1'b1, 1'b0);
        check("p_ghr", 32'(dut.ghr), 63);
        check("p_ctr31", ctr_at(31), 2);

        // Loop branch at 0x200 with ghr held at all ones -> idx 63
        branch_cycle("l1", 32'h200, 1'b1, 1'b0);
        check("l1_ctr63", ctr_at(63), 2);
        check("l1_ghr", 32'(dut.ghr), 63);
        branch_cycle("l2", 32'h200, 1'b1, 1'b1);
        check("l2_ctr63", ctr_at(63), 3);
        branch_cycle("l3", 32'h200, 1'b1, 1'b1);
        branch_cycle("l4", 32'h200, 1'b1, 1'b1);
        check("l4_ctr63", ctr_at(63), 3);
        check("l4_ghr", 32'(dut.ghr), 63);

        // ID stall: branch at 0x104 (idx 1^63=62) held for two cycles
        id_inst  = BEQ;
        id_pc    = 32'h104;
        id_stall = 1'b1;
        step();
        check("st1_ghr", 32'(dut.ghr), 63);
        check("st1_valid", 32'(ex_pred_valid), 0);
        step();
        check("st2_ghr", 32'(dut.ghr), 63);
        check("st2_valid", 32'(ex_pred_valid), 0);
        id_stall = 1'b0;
        #1;
        check("st_pred", 32'(id_br_taken), 0);
        step();
        check("st_ghr", 32'(dut.ghr), 62);
        check("st_valid", 32'(ex_pred_valid), 1);

        // EX hold 3 cycles with resolve high: one update, repair to 63
        ex_hold          = 1'b1;
        ex_resolve_valid = 1'b1;
        ex_actual_taken  = 1'b1;
        #1;
        check("h1_mis", 32'(ex_mispredict), 1);
        check("h1_pred", 32'(id_br_taken), 1);
        step();
        check("h2_valid", 32'(ex_pred_valid), 0);
        check("h2_mis", 32'(ex_mispredict), 0);
        step();
        step();
        check("h_ctr62", ctr_at(62), 2);
        check("h_ghr", 32'(dut.ghr), 63);
        ex_hold          = 1'b0;
        ex_resolve_valid = 1'b0;
        #1;
        check("h_pred", 32'(id_br_taken), 1);
        step();
        check("h_ghr_rel", 32'(dut.ghr), 63);
        check("h_valid_rel", 32'(ex_pred_valid), 1);

        // Mispredict in EX with flush; ID branch at 0x80 (idx 31, WT) is squashed
        id_pc            = 32'h80;
        ex_resolve_valid = 1'b1;
        ex_actual_taken  = 1'b0;
        ex_flush         = 1'b1;
        #1;
        check("f_pred", 32'(id_br_taken), 1);
        check("f_mis", 32'(ex_mispredict), 1);
        step();
        check("f_ghr", 32'(dut.ghr), 62);
        check("f_ctr62", ctr_at(62), 1);
        check("f_valid", 32'(ex_pred_valid), 0);

        // Resolve with empty shadow is ignored
        id_inst          = NOP;
        ex_flush         = 1'b0;
        ex_actual_taken  = 1'b1;
        #1;
        check("e_mis", 32'(ex_mispredict), 0);
        step();
        check("e_ctr62", ctr_at(62), 1);
        check("e_ghr", 32'(dut.ghr), 62);
        ex_resolve_valid = 1'b0;

        // Reset mid-stream with a branch in flight
        id_inst = BEQ;
        id_pc   = 32'h100;
        step();
        check("r_pre_valid", 32'(ex_pred_valid), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("r_ghr", 32'(dut.ghr), 0);
        check("r_valid", 32'(ex_pred_valid), 0);
        check("r_ctr0", ctr_at(0), 1);
        check("r_ctr31", ctr_at(31), 1);
        check("r_ctr63", ctr_at(63), 1);
        check("r_pred", 32'(id_br_taken), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
